// File: rtl/gray_decoder_monitor.sv
// gray_decoder_monitor
// Receive side of a Gray counter link. The remote counter's Gray bus is brought
// into the CLK domain through a plain flop chain and decoded to binary. Each
// change is classified as an up step, a down step or an illegal jump. The block
// keeps lock state and a sticky error flag with a saturating error count.
//
// Ports
//   CLK      in   system clock, rising edge
//   RESETL   in   asynchronous active-low reset
//   GRAY_IN  in   [WIDTH] Gray count from the remote domain (asynchronous)
//   ENABLE   in   monitor enable; low returns the FSM to IDLE
//   CLR_ERR  in   one-cycle pulse clearing ERR and ERR_CNT
//   BIN_OUT  out  [WIDTH] last accepted value in binary
//   STEP     out  one-cycle pulse per accepted legal step
//   DIR      out  direction of the last accepted step (1 = up, 0 = down)
//   LOCKED   out  high while the FSM is in LOCKED
//   ERR      out  sticky illegal-transition flag
//   ERR_CNT  out  [8] illegal-transition count, saturating at 255
//
// SYNC_STAGES is intended to be 2 or 3.
module gray_decoder_monitor #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESETL,
    input  logic [WIDTH-1:0] GRAY_IN,
    input  logic             ENABLE,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] BIN_OUT,
    output logic             STEP,
    output logic             DIR,
    output logic             LOCKED,
    output logic             ERR,
    output logic [7:0]       ERR_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    state_t           r_state;
    logic [WIDTH-1:0] r_prev_g;
    logic [1:0]       r_stable_cnt;
    logic [WIDTH-1:0] r_bin;
    logic             r_step;
    logic             r_dir;
    logic             r_locked;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    logic [WIDTH-1:0] w_g_s;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_prev_b;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_prev_g_nxt;
    logic [1:0]       w_stable_cnt_nxt;
    logic [WIDTH-1:0] w_bin_nxt;
    logic             w_step_nxt;
    logic             w_dir_nxt;
    logic             w_illegal;
    logic             w_err_nxt;
    logic [7:0]       w_err_cnt_nxt;

    // Synchroniser chain: bare flops, nothing between stages.
    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= GRAY_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_g_s    = r_sync[SYNC_STAGES-1];
    assign w_b      = gray2bin(w_g_s);
    assign w_prev_b = gray2bin(r_prev_g);
    assign w_inc    = w_prev_b + ONE;
    assign w_dec    = w_prev_b - ONE;

    // Next-state and datapath decisions for the acquisition/lock FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_prev_g_nxt     = r_prev_g;
        w_stable_cnt_nxt = r_stable_cnt;
        w_bin_nxt        = r_bin;
        w_step_nxt       = 1'b0;
        w_dir_nxt        = r_dir;
        w_illegal        = 1'b0;
        if (!ENABLE) begin
            w_state_nxt      = ST_IDLE;
            w_prev_g_nxt     = w_g_s;
            w_stable_cnt_nxt = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_prev_g_nxt     = w_g_s;
                    w_stable_cnt_nxt = 2'd0;
                    w_state_nxt      = ST_ACQ;
                end
                ST_ACQ: begin
                    if (w_g_s == r_prev_g) begin
                        // Third equal sample (count reaching 2) completes acquisition.
                        if (r_stable_cnt == 2'd1) begin
                            w_stable_cnt_nxt = 2'd2;
                            w_state_nxt      = ST_LOCK;
                            w_bin_nxt        = w_prev_b;
                        end else begin
                            w_stable_cnt_nxt = r_stable_cnt + 2'd1;
                        end
                    end else begin
                        w_prev_g_nxt     = w_g_s;
                        w_stable_cnt_nxt = 2'd0;
                    end
                end
                ST_LOCK: begin
                    if (w_b == w_inc) begin
                        w_step_nxt   = 1'b1;
                        w_dir_nxt    = 1'b1;
                        w_bin_nxt    = w_b;
                        w_prev_g_nxt = w_g_s;
                    end else if (w_b == w_dec) begin
                        w_step_nxt   = 1'b1;
                        w_dir_nxt    = 1'b0;
                        w_bin_nxt    = w_b;
                        w_prev_g_nxt = w_g_s;
                    end else if (w_b != w_prev_b) begin
                        // A one-bit Gray change can still be a non-adjacent jump.
                        w_illegal        = 1'b1;
                        w_prev_g_nxt     = w_g_s;
                        w_stable_cnt_nxt = 2'd0;
                        w_state_nxt      = ST_ACQ;
                    end else begin
                        w_state_nxt = ST_LOCK;
                    end
                end
                default: begin
                    w_state_nxt      = ST_IDLE;
                    w_prev_g_nxt     = w_g_s;
                    w_stable_cnt_nxt = 2'd0;
                end
            endcase
        end
    end

    // Error flag and counter: an illegal event in the same cycle beats CLR_ERR.
    always_comb begin
        w_err_nxt     = r_err;
        w_err_cnt_nxt = r_err_cnt;
        if (w_illegal) begin
            w_err_nxt = 1'b1;
            if (CLR_ERR) begin
                w_err_cnt_nxt = 8'd1;
            end else if (r_err_cnt != 8'hFF) begin
                w_err_cnt_nxt = r_err_cnt + 8'd1;
            end else begin
                w_err_cnt_nxt = r_err_cnt;
            end
        end else if (CLR_ERR) begin
            w_err_nxt     = 1'b0;
            w_err_cnt_nxt = 8'd0;
        end else begin
            w_err_nxt     = r_err;
            w_err_cnt_nxt = r_err_cnt;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            r_state      <= ST_IDLE;
            r_prev_g     <= '0;
            r_stable_cnt <= 2'd0;
            r_bin        <= '0;
            r_step       <= 1'b0;
            r_dir        <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_g     <= w_prev_g_nxt;
            r_stable_cnt <= w_stable_cnt_nxt;
            r_bin        <= w_bin_nxt;
            r_step       <= w_step_nxt;
            r_dir        <= w_dir_nxt;
            r_locked     <= (w_state_nxt == ST_LOCK);
            r_err        <= w_err_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
        end
    end

    assign BIN_OUT = r_bin;
    assign STEP    = r_step;
    assign DIR     = r_dir;
    assign LOCKED  = r_locked;
    assign ERR     = r_err;
    assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// Testbench for gray_decoder_monitor. Legal steps push their expected value,
// direction and due cycle into a scoreboard queue; a negedge monitor pops one
// entry per STEP pulse. Any STEP with nothing queued is reported.
module tb_gray_decoder_monitor;

    logic       CLK     = 1'b0;
    logic       RESETL  = 1'b0;
    logic [3:0] GRAY_IN = 4'b0000;
    logic       ENABLE  = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic [3:0] BIN_OUT;
    logic       STEP;
    logic       DIR;
    logic       LOCKED;
    logic       ERR;
    logic [7:0] ERR_CNT;

    gray_decoder_monitor #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .CLK     (CLK),
        .RESETL  (RESETL),
        .GRAY_IN (GRAY_IN),
        .ENABLE  (ENABLE),
        .CLR_ERR (CLR_ERR),
        .BIN_OUT (BIN_OUT),
        .STEP    (STEP),
        .DIR     (DIR),
        .LOCKED  (LOCKED),
        .ERR     (ERR),
        .ERR_CNT (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] bin;
        logic       dir;
        int         due;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_steps  = 0;
    int         cyc      = 0;
    logic [3:0] cur_b;

    // Edge counter used to check step latency.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive a legal step and queue its expected outcome three edges later.
    task automatic step_to(input logic [3:0] b, input logic d, input int hold);
        GRAY_IN = bin2gray(b);
        sb.push_back('{b, d, cyc + 3});
        cur_b = b;
        tick(hold);
    endtask

    task automatic wait_lock(input string tag);
        int k;
        k = 0;
        while (LOCKED !== 1'b1 && k < 30) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, LOCKED}, 32'd1);
    endtask

    // Scoreboard monitor: each STEP pulse consumes one queued expectation.
    always @(negedge CLK) begin
        if (STEP === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_step", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("step_bin", {28'd0, BIN_OUT}, {28'd0, mon_e.bin});
                check("step_dir", {31'd0, DIR}, {31'd0, mon_e.dir});
                check("step_latency", cyc, mon_e.due);
                n_steps++;
            end
        end
    end

    initial begin
        cur_b = 4'd0;
        // Reset state
        tick(2);
        check("rst_bin", {28'd0, BIN_OUT}, 32'd0);
        check("rst_step", {31'd0, STEP}, 32'd0);
        check("rst_dir", {31'd0, DIR}, 32'd0);
        check("rst_locked", {31'd0, LOCKED}, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);
        check("rst_errcnt", {24'd0, ERR_CNT}, 32'd0);
        RESETL = 1'b1;
        tick(2);

        // 1: acquire lock on a held 0000
        ENABLE = 1'b1;
        tick(1);
        check("t1_not_yet_locked", {31'd0, LOCKED}, 32'd0);
        wait_lock("t1_lock");
        check("t1_bin", {28'd0, BIN_OUT}, 32'd0);
        check("t1_err", {31'd0, ERR}, 32'd0);

        // 2: full up sequence with wrap 15 -> 0
        for (int i = 1; i <= 16; i++) begin
            step_to(4'(i % 16), 1'b1, 4);
        end
        check("t2_steps", n_steps, 32'd16);
        check("t2_dir", {31'd0, DIR}, 32'd1);
        check("t2_bin", {28'd0, BIN_OUT}, 32'd0);
        check("t2_err", {31'd0, ERR}, 32'd0);

        // 3: up to 5, up/down around it, then down-wrap 0 -> 15
        for (int b = 1; b <= 5; b++) begin
            step_to(4'(b), 1'b1, 4);
        end
        check("t3_at5", {28'd0, BIN_OUT}, 32'd5);
        step_to(4'd6, 1'b1, 4);
        check("t3_up6", {28'd0, BIN_OUT}, 32'd6);
        step_to(4'd7, 1'b1, 4);
        check("t3_up7", {28'd0, BIN_OUT}, 32'd7);
        step_to(4'd6, 1'b0, 4);
        check("t3_dn6", {28'd0, BIN_OUT}, 32'd6);
        check("t3_dn6_dir", {31'd0, DIR}, 32'd0);
        step_to(4'd5, 1'b0, 4);
        check("t3_dn5", {28'd0, BIN_OUT}, 32'd5);
        for (int b = 4; b >= 0; b--) begin
            step_to(4'(b), 1'b0, 4);
        end
        step_to(4'd15, 1'b0, 4);
        check("t3_wrap_bin", {28'd0, BIN_OUT}, 32'd15);
        check("t3_wrap_dir", {31'd0, DIR}, 32'd0);

        // 4: single-bit Gray change that is not adjacent (1 -> 14)
        step_to(4'd0, 1'b1, 4);
        step_to(4'd1, 1'b1, 4);
        GRAY_IN = 4'b1001;
        tick(3);
        check("t4_err", {31'd0, ERR}, 32'd1);
        check("t4_errcnt", {24'd0, ERR_CNT}, 32'd1);
        check("t4_unlocked", {31'd0, LOCKED}, 32'd0);
        check("t4_bin_hold", {28'd0, BIN_OUT}, 32'd1);
        wait_lock("t4_relock");
        check("t4_relock_bin", {28'd0, BIN_OUT}, 32'd14);
        check("t4_dir_hold", {31'd0, DIR}, 32'd1);
        cur_b = 4'd14;

        // 5: saturation and clear priority
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("t5_pre_clr_err", {31'd0, ERR}, 32'd0);
        check("t5_pre_clr_cnt", {24'd0, ERR_CNT}, 32'd0);
        for (int j = 1; j <= 256; j++) begin
            cur_b = cur_b + 4'd2;
            GRAY_IN = bin2gray(cur_b);
            tick(8);
            if (j == 254) check("t5_cnt254", {24'd0, ERR_CNT}, 32'd254);
            if (j == 255) check("t5_cnt255", {24'd0, ERR_CNT}, 32'd255);
        end
        check("t5_sat", {24'd0, ERR_CNT}, 32'd255);
        check("t5_err", {31'd0, ERR}, 32'd1);
        check("t5_locked", {31'd0, LOCKED}, 32'd1);
        check("t5_bin", {28'd0, BIN_OUT}, {28'd0, cur_b});
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("t5_clr_err", {31'd0, ERR}, 32'd0);
        check("t5_clr_cnt", {24'd0, ERR_CNT}, 32'd0);
        cur_b = cur_b + 4'd2;
        GRAY_IN = bin2gray(cur_b);
        tick(2);
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("t5_coinc_err", {31'd0, ERR}, 32'd1);
        check("t5_coinc_cnt", {24'd0, ERR_CNT}, 32'd1);
        wait_lock("t5_relock");
        check("t5_relock_bin", {28'd0, BIN_OUT}, {28'd0, cur_b});

        // 6: disable while the bus moves, re-enable, then reset mid-lock
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("t6_clr", {31'd0, ERR}, 32'd0);
        step_to(4'd1, 1'b1, 4);
        step_to(4'd2, 1'b1, 4);
        step_to(4'd3, 1'b1, 4);
        check("t6_at3", {28'd0, BIN_OUT}, 32'd3);
        ENABLE = 1'b0;
        GRAY_IN = 4'b0110;
        tick(5);
        check("t6_dis_locked", {31'd0, LOCKED}, 32'd0);
        check("t6_dis_err", {31'd0, ERR}, 32'd0);
        check("t6_dis_cnt", {24'd0, ERR_CNT}, 32'd0);
        check("t6_dis_bin", {28'd0, BIN_OUT}, 32'd3);
        ENABLE = 1'b1;
        tick(1);
        check("t6_reen_unlocked", {31'd0, LOCKED}, 32'd0);
        wait_lock("t6_relock");
        check("t6_relock_bin", {28'd0, BIN_OUT}, 32'd4);
        GRAY_IN = bin2gray(4'd6);
        tick(3);
        check("t6_jump_err", {31'd0, ERR}, 32'd1);
        wait_lock("t6_relock6");
        check("t6_bin6", {28'd0, BIN_OUT}, 32'd6);
        #2;
        RESETL = 1'b0;
        #1;
        check("t6_rst_bin", {28'd0, BIN_OUT}, 32'd0);
        check("t6_rst_step", {31'd0, STEP}, 32'd0);
        check("t6_rst_dir", {31'd0, DIR}, 32'd0);
        check("t6_rst_locked", {31'd0, LOCKED}, 32'd0);
        check("t6_rst_err", {31'd0, ERR}, 32'd0);
        check("t6_rst_cnt", {24'd0, ERR_CNT}, 32'd0);
        tick(2);
        RESETL = 1'b1;
        tick(1);
        check("t6_post_rst_unlocked", {31'd0, LOCKED}, 32'd0);
        wait_lock("t6_post_rst_lock");
        check("t6_post_rst_bin", {28'd0, BIN_OUT}, 32'd6);

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_decoder_monitor.md
Name: gray_decoder_monitor

Overview:
Receive side of the 4-bit Gray counter interface. Synchronises an asynchronous Gray-coded count bus into the CLK domain and decodes it to binary. Classifies every change as a legal up step, a legal down step, or an illegal jump. Tracks lock state and a saturating error count, so the clock datapath can consume a Gray count generated in another domain.

Parameters:
WIDTH, 4, width of Gray input and binary output
SYNC_STAGES, 2, synchroniser flop depth (legal 2..3)

Ports:
CLK  input  1  system clock, rising edge
RESETL  input  1  reset, asynchronous, active-low
GRAY_IN  input  WIDTH  Gray-coded count from the remote counter (asynchronous to CLK)
ENABLE  input  1  monitor enable; 0 forces IDLE
CLR_ERR  input  1  one-cycle pulse, clears ERR and ERR_CNT
BIN_OUT  output  WIDTH  last accepted value, binary
STEP  output  1  one-cycle pulse on each accepted legal step
DIR  output  1  direction of last accepted step: 1 = up, 0 = down
LOCKED  output  1  high in LOCKED state
ERR  output  1  sticky illegal-transition flag
ERR_CNT  output  8  illegal-transition count, saturates at 255

Behaviour:
- Reset (RESETL=0, asynchronous): every sync flop, prev_g, stable_cnt, BIN_OUT, STEP, DIR, ERR and ERR_CNT go to 0. LOCKED goes to 0. State goes to IDLE.
- Synchroniser: GRAY_IN passes through SYNC_STAGES flops. g_s is the last stage. No logic sits between the stages.
- Decode (combinational on g_s): b[W-1] = g[W-1]; b[i] = b[i+1] XOR g[i]. prev_b is the decode of prev_g.
- Legal up step: b == prev_b + 1 mod 2^WIDTH. Legal down step: b == prev_b - 1 mod 2^WIDTH. Any other b != prev_b is illegal, including single-bit Gray changes that are not ±1, e.g. 0001 -> 1001.
- Latency: a stable change on GRAY_IN reaches STEP/BIN_OUT SYNC_STAGES+1 rising edges later.
- Wrap: 1000 (15) -> 0000 (0) is a legal up step. 0000 -> 1000 is a legal down step.

State machine:
- IDLE
  - Actions: LOCKED=0; prev_g <= g_s every cycle; stable_cnt <= 0.
  - Transition: ENABLE=1 -> ACQ.
- ACQ
  - Actions: LOCKED=0. If g_s == prev_g, stable_cnt increments; else prev_g <= g_s and stable_cnt <= 0.
  - Transition: when stable_cnt reaches 2 (three equal samples), go to LOCKED and load BIN_OUT <= prev_b. STEP stays 0.
- LOCKED
  - Actions: LOCKED=1.
  - b == prev_b: no action.
  - Legal step: STEP=1 for one cycle; DIR <= 1 (up) or 0 (down); BIN_OUT <= b; prev_g <= g_s.
  - Illegal: ERR <= 1; ERR_CNT increments (saturating); prev_g <= g_s; stable_cnt <= 0; go to ACQ. BIN_OUT and DIR hold the last good value.
- From any state: ENABLE=0 -> IDLE on the next edge. BIN_OUT, DIR, ERR and ERR_CNT hold.

Error counter rules:
- CLR_ERR with no illegal event that cycle: ERR <= 0, ERR_CNT <= 0.
- CLR_ERR together with an illegal event: the event wins; ERR <= 1, ERR_CNT <= 1.
- ERR_CNT at 255 stays 255 on further errors. ERR stays 1 until CLR_ERR.
- STEP is never asserted in IDLE or ACQ, nor on an illegal transition.
- Reset asserted mid-operation returns to the reset values immediately. After reset release, reacquisition requires ENABLE plus three stable samples.

Test Plan:
1. Reset, ENABLE=1, GRAY_IN=0000 held -> LOCKED=1 at edge 2+3 after ENABLE; BIN_OUT=0, STEP=0, ERR=0.
2. Locked at 0; drive the full up sequence 0001,0011,0010,...,1000,0000, each held 4 cycles -> 16 STEP pulses; DIR=1; BIN_OUT reads 1..15,0; each pulse lands 3 edges after the GRAY_IN change; ERR=0.
3. Locked at BIN_OUT=5 (0111); drive 0101 then 0100 -> BIN_OUT 6 then 7. Then drive 0101, 0111 -> BIN_OUT 6 then 5 with DIR=0. Wrap check: from 0000 drive 1000 -> BIN_OUT=15, DIR=0.
4. Locked at 1 (0001); drive 1001 (index 14) -> no STEP; ERR=1; ERR_CNT=1; LOCKED=0; BIN_OUT stays 1. Hold 1001 -> relock with BIN_OUT=14 and STEP=0.
5. Inject 256 illegal jumps -> ERR_CNT=255. Pulse CLR_ERR on a cycle with no error -> ERR=0, ERR_CNT=0. Pulse CLR_ERR coincident with an illegal jump -> ERR=1, ERR_CNT=1.
6. Locked at 3; drop ENABLE for 5 cycles while GRAY_IN moves to 0110 (4) -> no STEP, no ERR, LOCKED=0. Re-enable -> relock with BIN_OUT=4. Then assert RESETL=0 mid-lock -> all outputs 0 immediately.
